// File: rtl/alu_share_sequencer.sv
// alu_share_sequencer
// Time-shares one combinational 8-bit compare/arithmetic unit between two
// requesters. Grants are round-robin. Operands are registered toward the unit.
// Results are captured into a response register and handed back with the
// winner's id.
//
// Handshake rule for every valid/ready pair in this block:
//   - A transfer happens on a rising clock edge where valid and ready are both high.
//   - A producer holds valid and its payload stable until that edge.
//   - ready may depend combinationally on valid; valid never depends on ready.
module alu_share_sequencer #(
   parameter int W     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [W-1:0]     req0_a,
   input  logic [W-1:0]     req0_b,
   input  logic [1:0]       req0_op,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [W-1:0]     req1_a,
   input  logic [W-1:0]     req1_b,
   input  logic [1:0]       req1_op,
   output logic             req1_ready,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [1:0]       alu_op,
   input  logic [W-1:0]     alu_y,
   input  logic             alu_parity,
   input  logic             alu_overflow,
   input  logic             alu_greater,
   input  logic             alu_is_eq,
   input  logic             alu_less,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [W-1:0]     rsp_y,
   output logic             rsp_parity,
   output logic             rsp_overflow,
   output logic             rsp_greater,
   output logic             rsp_is_eq,
   output logic             rsp_less,
   output logic             busy,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   rr_ptr;   // requester that wins when both are valid
   logic   cur_id;   // winner of the operation in flight
   logic   win_id;
   logic   win_valid;
   logic   accept;

   // Arbitration: a lone requester always wins, and a tie goes to rr_ptr.
   always_comb begin
      win_valid = req0_valid | req1_valid;
      win_id    = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
   end

   assign accept     = (state == IDLE) && win_valid && !rst;
   assign req0_ready = accept && !win_id;
   assign req1_ready = accept && win_id;
   assign busy       = (state != IDLE);
   assign state_dbg  = state;

   // Sequencer: accept in IDLE, one EXEC cycle for the unit to settle, then hold the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= 1'b0;
         cur_id       <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_y        <= '0;
         rsp_parity   <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_greater  <= 1'b0;
         rsp_is_eq    <= 1'b0;
         rsp_less     <= 1'b0;
         gnt_cnt0     <= '0;
         gnt_cnt1     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a  <= win_id ? req1_a  : req0_a;
                  alu_b  <= win_id ? req1_b  : req0_b;
                  alu_op <= win_id ? req1_op : req0_op;
                  cur_id <= win_id;
                  rr_ptr <= ~win_id;
                  if (win_id) begin
                     if (gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + 1'b1;
                  end else begin
                     if (gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + 1'b1;
                  end
                  state <= EXEC;
               end
            end
            EXEC: begin
               // The response id is copied here so rsp_* only ever change on capture.
               rsp_id       <= cur_id;
               rsp_y        <= alu_y;
               rsp_parity   <= alu_parity;
               rsp_overflow <= alu_overflow;
               rsp_greater  <= alu_greater;
               rsp_is_eq    <= alu_is_eq;
               rsp_less     <= alu_less;
               rsp_valid    <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Bench for alu_share_sequencer: a stub compare/arithmetic unit, a
// transaction-level reference model with an expected-response queue,
// and directed plus randomized requester traffic.
module tb_alu_share_sequencer;

   localparam int W     = 8;
   localparam int CNT_W = 8;
   localparam int RW    = 14;   // {id, y[7:0], parity, overflow, greater, is_eq, less}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic [1:0]       req0_op, req1_op;
   logic [W-1:0]     alu_a, alu_b, alu_y;
   logic [1:0]       alu_op;
   logic             alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0]     rsp_y;
   logic             rsp_parity, rsp_overflow, rsp_greater, rsp_is_eq, rsp_less;
   logic             busy;
   logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
   logic [1:0]       state_dbg;

   alu_share_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_y(alu_y), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
      .alu_greater(alu_greater), .alu_is_eq(alu_is_eq), .alu_less(alu_less),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .rsp_parity(rsp_parity), .rsp_overflow(rsp_overflow), .rsp_greater(rsp_greater),
      .rsp_is_eq(rsp_is_eq), .rsp_less(rsp_less),
      .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .state_dbg(state_dbg)
   );

   // ---------------- stub unit ----------------
   // op 0: add (overflow = carry), 1: sub (overflow = borrow), 2: and, 3: xor.
   function automatic logic [12:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      logic [8:0] s;
      logic [7:0] y;
      logic       ov;
      case (op)
         2'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; ov = s[8]; end
         2'd1: begin y = a - b; ov = (a < b); end
         2'd2: begin y = a & b; ov = 1'b0; end
         default: begin y = a ^ b; ov = 1'b0; end
      endcase
      return {y, ^y, ov, a > b, a == b, a < b};
   endfunction

   localparam logic [12:0] OVR_VAL = {8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   logic        ovr = 1'b0;
   logic [12:0] stub_out;
   always_comb stub_out = ovr ? OVR_VAL : alu_ref(alu_a, alu_b, alu_op);
   assign {alu_y, alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less} = stub_out;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] rsp_word();
      return {rsp_id, rsp_y, rsp_parity, rsp_overflow, rsp_greater, rsp_is_eq, rsp_less};
   endfunction

   // ---------------- reference model / scoreboard ----------------
   // Transaction view: at most one operation is outstanding; a grant needs no
   // outstanding operation; the response shows two cycles after the grant and
   // retires on the cycle the consumer takes it.
   logic [RW-1:0] exp_q[$];
   int            grant_log[$];
   int            grant_cyc[$];
   bit            pending = 1'b0;
   int            cyc = 0;
   int            acc_cyc = 0;
   bit            next_pri = 1'b0;
   int            cnt0_m = 0, cnt1_m = 0;
   logic [7:0]    ma = '0, mb = '0;
   logic [1:0]    mop = '0;
   bit            m_w, m_r0, m_r1, m_rv;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         pending = 1'b0; next_pri = 1'b0; cnt0_m = 0; cnt1_m = 0;
         ma = '0; mb = '0; mop = '0;
         exp_q.delete();
      end else begin
         m_w  = (req0_valid && req1_valid) ? next_pri : req1_valid;
         m_r0 = !pending && req0_valid && !m_w;
         m_r1 = !pending && req1_valid && m_w;
         m_rv = pending && (cyc >= acc_cyc + 2);
         check("req0_ready", req0_ready, m_r0);
         check("req1_ready", req1_ready, m_r1);
         check("busy", busy, pending);
         check("rsp_valid", rsp_valid, m_rv);
         check("alu_a", alu_a, ma);
         check("alu_b", alu_b, mb);
         check("alu_op", alu_op, mop);
         check("gnt_cnt0", gnt_cnt0, cnt0_m);
         check("gnt_cnt1", gnt_cnt1, cnt1_m);
         if (m_rv && exp_q.size() > 0) begin
            check("rsp_payload", rsp_word(), exp_q[0]);
            if (rsp_ready) begin
               void'(exp_q.pop_front());
               pending = 1'b0;
            end
         end
         if (m_r0 || m_r1) begin
            ma  = m_w ? req1_a  : req0_a;
            mb  = m_w ? req1_b  : req0_b;
            mop = m_w ? req1_op : req0_op;
            exp_q.push_back({m_w, ovr ? OVR_VAL : alu_ref(ma, mb, mop)});
            next_pri = !m_w;
            if (m_w) cnt1_m = (cnt1_m < 255) ? cnt1_m + 1 : 255;
            else     cnt0_m = (cnt0_m < 255) ? cnt0_m + 1 : 255;
            pending = 1'b1;
            acc_cyc = cyc;
            grant_log.push_back(int'(m_w));
            grant_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic do_reset();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; ovr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_req0_ready"}, req0_ready, 1'b0);
      check({pfx, "_req1_ready"}, req1_ready, 1'b0);
      check({pfx, "_alu_a"}, alu_a, 8'h00);
      check({pfx, "_alu_b"}, alu_b, 8'h00);
      check({pfx, "_alu_op"}, alu_op, 2'b00);
      check({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
      check({pfx, "_rsp_word"}, rsp_word(), '0);
      check({pfx, "_busy"}, busy, 1'b0);
      check({pfx, "_gnt_cnt0"}, gnt_cnt0, 8'h00);
      check({pfx, "_gnt_cnt1"}, gnt_cnt1, 8'h00);
   endtask

   task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      bit got = 1'b0;
      if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
      else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
         @(posedge clk);
         #1;
      end
      if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
      check("issue_accepted", got, 1'b1);
   endtask

   task automatic traffic(input int n, input int p0, input int p1, input int prdy);
      bit g0, g1;
      for (int i = 0; i < n; i++) begin
         rsp_ready = ($urandom_range(99) < prdy);
         if (!req0_valid && $urandom_range(99) < p0) begin
            req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
         end
         if (!req1_valid && $urandom_range(99) < p1) begin
            req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
         end
         @(negedge clk);
         g0 = req0_ready; g1 = req1_ready;
         @(posedge clk);
         #1;
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
      end
   endtask

   // Lets held requests get granted, takes all responses, and waits for IDLE.
   task automatic drain();
      bit g0, g1;
      bit done = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         g0 = req0_ready; g1 = req1_ready;
         @(posedge clk);
         #1;
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
         done = !req0_valid && !req1_valid && !busy && !rsp_valid;
      end
      check("drain_done", done, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   logic [RW-1:0] snap;
   int            gl_start;

   initial begin
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      #1;
      check_reset_vals("reset");
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;

      // 1: single request, a + b
      req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 2'b00;
      #1;
      check("t1_req0_ready", req0_ready, 1'b1);
      check("t1_req1_ready", req1_ready, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      check("t1_alu_a", alu_a, 8'h05);
      check("t1_alu_b", alu_b, 8'h03);
      check("t1_rsp_valid_t1", rsp_valid, 1'b0);
      check("t1_gnt_cnt0", gnt_cnt0, 8'd1);
      @(posedge clk); #1;
      check("t1_rsp_valid_t2", rsp_valid, 1'b1);
      check("t1_rsp_y", rsp_y, 8'h08);
      check("t1_rsp_id", rsp_id, 1'b0);
      @(posedge clk); #1;
      check("t1_rsp_valid_after", rsp_valid, 1'b0);

      // 2: contention, round-robin every 3 cycles
      do_reset();
      gl_start = grant_log.size();
      traffic(12, 100, 100, 100);
      drain();
      check("t2_grants", grant_log.size() - gl_start >= 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (gl_start + i < grant_log.size()) begin
            check("t2_grant_id", grant_log[gl_start + i], i % 2);
            if (i > 0) check("t2_grant_gap", grant_cyc[gl_start + i] - grant_cyc[gl_start + i - 1], 3);
         end
      end

      // 3: backpressure for 10 cycles
      rsp_ready = 1'b0;
      issue(1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
      req1_valid = 1'b1; req1_a = 8'h9C; req1_b = 8'h41; req1_op = 2'd1;
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 2'd3;
      @(posedge clk); #1;
      check("t3_rsp_valid", rsp_valid, 1'b1);
      snap = rsp_word();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t3_rsp_stable", rsp_word(), snap);
         check("t3_busy", busy, 1'b1);
         check("t3_readys", {req0_ready, req1_ready}, 2'b00);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_resume_busy", busy, 1'b0);
      check("t3_resume_req1", req1_ready, 1'b1);
      drain();

      // 4: flag capture, then stub changes during RESP
      ovr = 1'b1; rsp_ready = 1'b0;
      issue(1'b0, 8'h03, 8'h03, 2'b00);
      @(posedge clk); #1;
      check("t4_rsp_valid", rsp_valid, 1'b1);
      check("t4_rsp_word", rsp_word(), {1'b0, OVR_VAL});
      ovr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("t4_rsp_hold", rsp_word(), {1'b0, OVR_VAL});
      end
      drain();

      // randomized traffic with random backpressure
      traffic(300, 50, 50, 60);
      drain();

      // 5: async reset in EXEC
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h5A; req0_op = 2'd2;
      @(posedge clk); #3;
      check("t5_in_exec", busy, 1'b1);
      req1_valid = 1'b1; req1_a = 8'h77; req1_b = 8'h11; req1_op = 2'd0;
      rst = 1'b1;
      #1;
      check_reset_vals("t5");
      @(posedge clk); #1;
      rst = 1'b0;
      req0_a = 8'h20; req0_b = 8'h30; req0_op = 2'd1;
      #1;
      check("t5_first_req0", req0_ready, 1'b1);
      check("t5_first_req1", req1_ready, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      drain();

      // 6: counter saturation
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 300; i++) issue(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
      drain();
      check("t6_gnt_cnt1", gnt_cnt1, 8'hFF);
      check("t6_gnt_cnt0", gnt_cnt0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
